// File: rtl/iob_merge_rr_pkg.sv
// Shared types and sizing helpers for the round-robin IOb merge.
package iob_merge_rr_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Grant index width: never narrower than one bit.
    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned N_MASTERS_DFLT = 2;
    localparam int unsigned SEL_W          = sel_width(N_MASTERS_DFLT);

endpackage

// File: rtl/iob_rr_arbiter.sv
// Combinational picker: round-robin upward from last_gnt+1, or lowest index first.
module iob_rr_arbiter
#(
    parameter int unsigned N     = 2,
    parameter int unsigned SEL_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] last_gnt,
    input  logic             rr_en,
    output logic [SEL_W-1:0] gnt_idx,
    output logic             gnt_vld
);

    logic             lo_hit;
    logic             hi_hit;
    logic [SEL_W-1:0] lo_idx;
    logic [SEL_W-1:0] hi_idx;

    // Lowest requester overall, and lowest requester above last_gnt; the latter wins in RR mode.
    always_comb begin
        lo_hit = 1'b0;
        hi_hit = 1'b0;
        lo_idx = '0;
        hi_idx = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (req[i] && !lo_hit) begin
                lo_hit = 1'b1;
                lo_idx = SEL_W'(i);
            end
            if (req[i] && rr_en && !hi_hit && (SEL_W'(i) > last_gnt)) begin
                hi_hit = 1'b1;
                hi_idx = SEL_W'(i);
            end
        end
        gnt_vld = lo_hit;
        gnt_idx = hi_hit ? hi_idx : lo_idx;
    end

endmodule

// File: rtl/iob_merge_rr.sv
// Merges N IOb masters onto one slave port with RR or fixed-priority arbitration
// and a deferred, single-pulse cache invalidate.
module iob_merge_rr
    import iob_merge_rr_pkg::*;
#(
    parameter int unsigned N_MASTERS = 2,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned RR_EN     = 1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          cke_i,

    input  logic [N_MASTERS-1:0]          m_avalid_i,
    input  logic [N_MASTERS*ADDR_W-1:0]   m_addr_i,
    input  logic [N_MASTERS*DATA_W-1:0]   m_wdata_i,
    input  logic [N_MASTERS*DATA_W/8-1:0] m_wstrb_i,
    output logic [DATA_W-1:0]             m_rdata_o,
    output logic [N_MASTERS-1:0]          m_ack_o,

    output logic                          s_avalid_o,
    output logic [ADDR_W-1:0]             s_addr_o,
    output logic [DATA_W-1:0]             s_wdata_o,
    output logic [DATA_W/8-1:0]           s_wstrb_o,
    input  logic [DATA_W-1:0]             s_rdata_i,
    input  logic                          s_ack_i,

    input  logic                          inv_i,
    output logic                          s_inv_o,
    output logic                          busy_o
);

    localparam int unsigned GNT_W  = sel_width(N_MASTERS);
    localparam int unsigned STRB_W = DATA_W / 8;

    state_t                 state;
    state_t                 state_nxt;
    logic [GNT_W-1:0]       gnt_idx;
    logic [GNT_W-1:0]       gnt_nxt;
    logic [GNT_W-1:0]       last_gnt;
    logic [GNT_W-1:0]       last_nxt;
    logic                   inv_pend;
    logic                   inv_nxt;

    logic [GNT_W-1:0]       arb_idx;
    logic                   arb_vld;

    logic                   sel_avalid;
    logic [ADDR_W-1:0]      sel_addr;
    logic [DATA_W-1:0]      sel_wdata;
    logic [STRB_W-1:0]      sel_wstrb;
    logic [N_MASTERS-1:0]   sel_onehot;
    logic                   ack;

    iob_rr_arbiter #(
        .N     (N_MASTERS),
        .SEL_W (GNT_W)
    ) u_arb (
        .req      (m_avalid_i),
        .last_gnt (last_gnt),
        .rr_en    (RR_EN != 0),
        .gnt_idx  (arb_idx),
        .gnt_vld  (arb_vld)
    );

    // Select the granted master's request fields.
    always_comb begin
        sel_avalid = 1'b0;
        sel_addr   = '0;
        sel_wdata  = '0;
        sel_wstrb  = '0;
        sel_onehot = '0;
        for (int i = 0; i < int'(N_MASTERS); i++) begin
            if (GNT_W'(i) == gnt_idx) begin
                sel_avalid    = m_avalid_i[i];
                sel_addr      = m_addr_i[i*ADDR_W +: ADDR_W];
                sel_wdata     = m_wdata_i[i*DATA_W +: DATA_W];
                sel_wstrb     = m_wstrb_i[i*STRB_W +: STRB_W];
                sel_onehot[i] = 1'b1;
            end
        end
    end

    // Next state and outputs; responses are suppressed when the state cannot advance.
    always_comb begin
        state_nxt  = state;
        gnt_nxt    = gnt_idx;
        last_nxt   = last_gnt;
        inv_nxt    = inv_pend | inv_i;
        ack        = 1'b0;
        s_inv_o    = 1'b0;
        s_avalid_o = 1'b0;
        s_addr_o   = '0;
        s_wdata_o  = '0;
        s_wstrb_o  = '0;
        busy_o     = 1'b0;

        case (state)
            ST_IDLE: begin
                if (inv_pend) begin
                    s_inv_o = cke_i & ~rst_i;
                    inv_nxt = inv_i;
                end else if (arb_vld) begin
                    gnt_nxt   = arb_idx;
                    state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                busy_o     = 1'b1;
                s_avalid_o = sel_avalid;
                s_addr_o   = sel_addr;
                s_wdata_o  = sel_wdata;
                s_wstrb_o  = sel_wstrb;
                if (s_ack_i) begin
                    ack       = cke_i & ~rst_i;
                    last_nxt  = gnt_idx;
                    state_nxt = ST_IDLE;
                end else if (!sel_avalid) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        m_ack_o   = ack ? sel_onehot : '0;
        m_rdata_o = ack ? s_rdata_i : '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= ST_IDLE;
            gnt_idx  <= '0;
            last_gnt <= GNT_W'(N_MASTERS - 1);
            inv_pend <= 1'b0;
        end else if (cke_i) begin
            state    <= state_nxt;
            gnt_idx  <= gnt_nxt;
            last_gnt <= last_nxt;
            inv_pend <= inv_nxt;
        end
    end

endmodule

// File: tb/tb_iob_merge_rr.sv
// Directed bench: a 2-master RR instance and a 4-master fixed-priority instance.
module tb_iob_merge_rr;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_bad = 0;

    // dut_a: N=2, round-robin
    logic        rst_a, cke_a, inv_a, s_ack_a;
    logic [1:0]  avalid_a;
    logic [63:0] addr_a, wdata_a;
    logic [7:0]  wstrb_a;
    logic [31:0] s_rdata_a, m_rdata_a, s_addr_a, s_wdata_a;
    logic [1:0]  m_ack_a;
    logic [3:0]  s_wstrb_a;
    logic        s_avalid_a, s_inv_a, busy_a;

    // dut_b: N=4, fixed priority
    logic         rst_b, cke_b, inv_b, s_ack_b;
    logic [3:0]   avalid_b;
    logic [127:0] addr_b, wdata_b;
    logic [15:0]  wstrb_b;
    logic [31:0]  s_rdata_b, m_rdata_b, s_addr_b, s_wdata_b;
    logic [3:0]   m_ack_b;
    logic [3:0]   s_wstrb_b;
    logic         s_avalid_b, s_inv_b, busy_b;

    iob_merge_rr #(.N_MASTERS(2), .ADDR_W(32), .DATA_W(32), .RR_EN(1)) dut_a (
        .clk_i(clk_i), .rst_i(rst_a), .cke_i(cke_a),
        .m_avalid_i(avalid_a), .m_addr_i(addr_a), .m_wdata_i(wdata_a), .m_wstrb_i(wstrb_a),
        .m_rdata_o(m_rdata_a), .m_ack_o(m_ack_a),
        .s_avalid_o(s_avalid_a), .s_addr_o(s_addr_a), .s_wdata_o(s_wdata_a), .s_wstrb_o(s_wstrb_a),
        .s_rdata_i(s_rdata_a), .s_ack_i(s_ack_a),
        .inv_i(inv_a), .s_inv_o(s_inv_a), .busy_o(busy_a)
    );

    iob_merge_rr #(.N_MASTERS(4), .ADDR_W(32), .DATA_W(32), .RR_EN(0)) dut_b (
        .clk_i(clk_i), .rst_i(rst_b), .cke_i(cke_b),
        .m_avalid_i(avalid_b), .m_addr_i(addr_b), .m_wdata_i(wdata_b), .m_wstrb_i(wstrb_b),
        .m_rdata_o(m_rdata_b), .m_ack_o(m_ack_b),
        .s_avalid_o(s_avalid_b), .s_addr_o(s_addr_b), .s_wdata_o(s_wdata_b), .s_wstrb_o(s_wstrb_b),
        .s_rdata_i(s_rdata_b), .s_ack_i(s_ack_b),
        .inv_i(inv_b), .s_inv_o(s_inv_b), .busy_o(busy_b)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // One dut_a transaction: BUSY cycle with ack, then the bubble cycle.
    task automatic txn_a(input string tag, input int idx, input logic [31:0] exp_addr,
                         input logic [31:0] rdata);
        logic [1:0] exp_ack;
        exp_ack = 2'b01 << idx;
        step();
        check({tag, "_busy"}, 64'(busy_a), 64'd1);
        check({tag, "_addr"}, 64'(s_addr_a), 64'(exp_addr));
        s_ack_a   = 1'b1;
        s_rdata_a = rdata;
        #1;
        check({tag, "_ack"}, 64'(m_ack_a), 64'(exp_ack));
        check({tag, "_rdata"}, 64'(m_rdata_a), 64'(rdata));
        step();
        s_ack_a   = 1'b0;
        s_rdata_a = '0;
        #1;
        check({tag, "_bubble_avalid"}, 64'(s_avalid_a), 64'd0);
        check({tag, "_bubble_ack"}, 64'(m_ack_a), 64'd0);
    endtask

    initial begin
        int pulses;
        rst_a = 1'b1; cke_a = 1'b1; inv_a = 1'b0; s_ack_a = 1'b0; avalid_a = '0;
        addr_a = {32'h0000_0200, 32'h0000_0100}; wdata_a = '0; wstrb_a = '0; s_rdata_a = '0;
        rst_b = 1'b1; cke_b = 1'b1; inv_b = 1'b0; s_ack_b = 1'b0; avalid_b = '0;
        addr_b = {32'h0000_3300, 32'h0000_2200, 32'h0000_1100, 32'h0000_1000};
        wdata_b = {32'h0, 32'hDEAD_BEEF, 32'h0, 32'h0}; wstrb_b = '0; s_rdata_b = '0;
        step();
        step();
        check("rst_busy_a", 64'(busy_a), 64'd0);
        check("rst_avalid_a", 64'(s_avalid_a), 64'd0);
        check("rst_ack_b", 64'(m_ack_b), 64'd0);
        check("rst_inv_b", 64'(s_inv_b), 64'd0);
        check("rst_rdata_b", 64'(m_rdata_b), 64'd0);
        rst_a = 1'b0;
        rst_b = 1'b0;

        // Round-robin alternation with both masters requesting continuously
        avalid_a = 2'b11;
        txn_a("rr0", 0, 32'h0000_0100, 32'h0000_A000);
        txn_a("rr1", 1, 32'h0000_0200, 32'h0000_A001);
        txn_a("rr2", 0, 32'h0000_0100, 32'h0000_A002);
        txn_a("rr3", 1, 32'h0000_0200, 32'h0000_A003);

        // Reset in BUSY: master 0 served last, master 1 in flight, reset restores start point
        avalid_a = 2'b01;
        txn_a("pre0", 0, 32'h0000_0100, 32'h0000_B000);
        avalid_a = 2'b10;
        step();
        check("pre1_busy", 64'(busy_a), 64'd1);
        check("pre1_addr", 64'(s_addr_a), 64'h200);
        rst_a    = 1'b1;
        avalid_a = 2'b11;
        step();
        check("rstbusy_busy", 64'(busy_a), 64'd0);
        check("rstbusy_avalid", 64'(s_avalid_a), 64'd0);
        check("rstbusy_ack", 64'(m_ack_a), 64'd0);
        rst_a = 1'b0;
        txn_a("post", 0, 32'h0000_0100, 32'h0000_C000);
        avalid_a = 2'b00;

        // Fixed priority: master 1 always beats master 3
        avalid_b = 4'b1010;
        for (int k = 0; k < 3; k++) begin
            step();
            check("fp_addr", 64'(s_addr_b), 64'h1100);
            s_ack_b = 1'b1;
            #1;
            check("fp_ack", 64'(m_ack_b), 64'b0010);
            step();
            s_ack_b = 1'b0;
            #1;
            check("fp_bubble", 64'(busy_b), 64'd0);
        end
        avalid_b = 4'b0000;
        step();

        // Invalidate raised mid-BUSY is served right after the ack, before the next grant
        avalid_b = 4'b0001;
        step();
        check("inv_addr", 64'(s_addr_b), 64'h1000);
        check("inv_rd_strb", 64'(s_wstrb_b), 64'h0);
        inv_b = 1'b1;
        step();
        inv_b = 1'b0;
        #1;
        check("inv_busy_noinv", 64'(s_inv_b), 64'd0);
        s_ack_b   = 1'b1;
        s_rdata_b = 32'h55;
        #1;
        check("inv_ack", 64'(m_ack_b), 64'b0001);
        step();
        s_ack_b   = 1'b0;
        s_rdata_b = '0;
        #1;
        check("inv_pulse", 64'(s_inv_b), 64'd1);
        check("inv_no_avalid", 64'(s_avalid_b), 64'd0);
        step();
        check("inv_pulse_end", 64'(s_inv_b), 64'd0);
        check("inv_grant_deferred", 64'(busy_b), 64'd0);
        step();
        check("inv_then_grant", 64'(busy_b), 64'd1);
        check("inv_none_in_busy", 64'(s_inv_b), 64'd0);
        s_ack_b = 1'b1;
        step();
        s_ack_b  = 1'b0;
        avalid_b = 4'b0000;
        step();

        // Two invalidates during one BUSY merge into a single pulse
        avalid_b = 4'b0001;
        step();
        inv_b = 1'b1;
        step();
        inv_b = 1'b0;
        step();
        step();
        inv_b = 1'b1;
        step();
        inv_b   = 1'b0;
        s_ack_b = 1'b1;
        step();
        s_ack_b  = 1'b0;
        avalid_b = 4'b0000;
        pulses   = 0;
        for (int k = 0; k < 4; k++) begin
            #1;
            if (s_inv_b) pulses++;
            step();
        end
        check("inv_merged_pulses", 64'(pulses), 64'd1);

        // Master 2 write, stalled by cke, then read back
        avalid_b        = 4'b0100;
        wstrb_b[11:8]   = 4'hF;
        step();
        check("wr_strb", 64'(s_wstrb_b), 64'hF);
        check("wr_data", 64'(s_wdata_b), 64'hDEAD_BEEF);
        check("wr_addr", 64'(s_addr_b), 64'h2200);
        cke_b   = 1'b0;
        s_ack_b = 1'b1;
        #1;
        check("cke_low_noack", 64'(m_ack_b), 64'd0);
        step();
        check("cke_low_hold", 64'(busy_b), 64'd1);
        cke_b = 1'b1;
        #1;
        check("wr_ack", 64'(m_ack_b), 64'b0100);
        step();
        s_ack_b       = 1'b0;
        wstrb_b[11:8] = 4'h0;
        step();
        check("rd_strb", 64'(s_wstrb_b), 64'h0);
        s_ack_b   = 1'b1;
        s_rdata_b = 32'hDEAD_BEEF;
        #1;
        check("rd_rdata", 64'(m_rdata_b), 64'hDEAD_BEEF);
        check("rd_ack", 64'(m_ack_b), 64'b0100);
        step();
        s_ack_b   = 1'b0;
        avalid_b  = 4'b0000;
        #1;
        check("rdata_idle_zero", 64'(m_rdata_b), 64'd0);
        check("ack_idle_zero", 64'(m_ack_b), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
